// File: rtl/mem_access_unit.sv
// Load/store front end for a data RAM that has no byte enables.
// Sub-word stores are read-modify-write; loads return sign- or zero-extended data.
module mem_access_unit #(
  parameter int data_width = 32,
  parameter int addr_width = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [1:0]            SIZE,
  input  logic                  UNSIGNED,
  input  logic [addr_width+1:0] BYTE_ADDR,
  input  logic [data_width-1:0] WDATA,
  output logic                  READY,
  output logic                  ACK,
  output logic                  ERR,
  output logic [data_width-1:0] RDATA,
  output logic [addr_width-1:0] ADDR_W,
  output logic                  ENABLE_W,
  output logic [data_width-1:0] Q_W,
  output logic [addr_width-1:0] ADDR_R,
  input  logic [data_width-1:0] Q_R
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic                  we_q;
  logic                  uns_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic [data_width-1:0] wdata_q;
  logic [data_width-1:0] buf_q;
  logic [data_width-1:0] rdata_q;
  logic [data_width-1:0] q_w_q;
  logic [addr_width-1:0] addr_w_q;
  logic [addr_width-1:0] addr_r_q;
  logic                  err_q;

  logic                  illegal;
  logic [addr_width-1:0] req_word;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [data_width-1:0] load_data;
  logic [data_width-1:0] wr_data;

  assign req_word = BYTE_ADDR[addr_width+1:2];
  assign illegal  = (SIZE == 2'b11) ||
                    (SIZE == 2'b01 && BYTE_ADDR[0]) ||
                    (SIZE == 2'b10 && BYTE_ADDR[1:0] != 2'b00);

  always_comb begin
    lane_byte = Q_R[{lane_q, 3'b000} +: 8];
    lane_half = Q_R[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = Q_R;
    endcase
  end

  // Store data: whole word for word stores, otherwise the old word with the target lane(s) replaced.
  always_comb begin
    wr_data = buf_q;
    case (size_q)
      2'b00:   wr_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   wr_data[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_data = wdata_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      q_w_q    <= '0;
      addr_w_q <= '0;
      addr_r_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= WE;
              size_q  <= SIZE;
              uns_q   <= UNSIGNED;
              lane_q  <= BYTE_ADDR[1:0];
              wdata_q <= WDATA;
              // Word stores skip the read; everything else reads the word first.
              if (WE && SIZE == 2'b10) begin
                addr_w_q <= req_word;
                state    <= WR;
              end else begin
                addr_r_q <= req_word;
                state    <= RD;
              end
            end
          end
        end
        RD: begin
          buf_q <= Q_R;
          if (we_q) begin
            addr_w_q <= addr_r_q;
            state    <= WR;
          end else begin
            rdata_q <= load_data;
            state   <= DONE;
          end
        end
        WR: begin
          q_w_q <= wr_data;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign READY    = (state == IDLE);
  assign ACK      = (state == DONE);
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign ENABLE_W = (state == WR) && !RST;
  assign ADDR_W   = addr_w_q;
  assign Q_W      = (state == WR) ? wr_data : q_w_q;
  assign ADDR_R   = addr_r_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural RAM (combinational read, synchronous write).
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ;
  logic        WE;
  logic [1:0]  SIZE;
  logic        UNSIGNED;
  logic [11:0] BYTE_ADDR;
  logic [31:0] WDATA;
  logic        READY;
  logic        ACK;
  logic        ERR;
  logic [31:0] RDATA;
  logic [9:0]  ADDR_W;
  logic        ENABLE_W;
  logic [31:0] Q_W;
  logic [9:0]  ADDR_R;
  logic [31:0] Q_R;

  logic [31:0] ram [0:1023];
  logic        preset_en = 1'b0;
  logic [9:0]  preset_addr = '0;
  logic [31:0] preset_data = '0;
  int          wr_count = 0;

  int checks = 0;
  int errors = 0;
  int wc;
  int ack_n;
  int acc_n;
  int ack_cyc [3];
  logic rdy;

  always #5 CLK = ~CLK;

  mem_access_unit #(.data_width(32), .addr_width(10)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .SIZE(SIZE), .UNSIGNED(UNSIGNED),
    .BYTE_ADDR(BYTE_ADDR), .WDATA(WDATA), .READY(READY), .ACK(ACK), .ERR(ERR),
    .RDATA(RDATA), .ADDR_W(ADDR_W), .ENABLE_W(ENABLE_W), .Q_W(Q_W),
    .ADDR_R(ADDR_R), .Q_R(Q_R)
  );

  assign Q_R = ram[ADDR_R];

  always @(posedge CLK) begin
    if (preset_en) begin
      ram[preset_addr] <= preset_data;
    end else if (ENABLE_W) begin
      ram[ADDR_W] <= Q_W;
      wr_count    <= wr_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic presetWord(input logic [9:0] a, input logic [31:0] d);
    preset_en   = 1'b1;
    preset_addr = a;
    preset_data = d;
    tick();
    preset_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [11:0] addr, input logic [31:0] wdata);
    REQ       = 1'b1;
    WE        = we;
    SIZE      = size;
    UNSIGNED  = uns;
    BYTE_ADDR = addr;
    WDATA     = wdata;
  endtask

  task automatic doLoad(input string tag, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] expected);
    applyStimulus(1'b0, size, uns, addr, 32'h0);
    checkOutput($sformatf("%s_ready", tag), {31'h0, READY}, 32'h1);
    tick();
    REQ = 1'b0;
    checkOutput($sformatf("%s_addr_r", tag), {22'h0, ADDR_R}, {22'h0, addr[11:2]});
    checkOutput($sformatf("%s_ack_early", tag), {31'h0, ACK}, 32'h0);
    tick();
    checkOutput($sformatf("%s_ack", tag), {31'h0, ACK}, 32'h1);
    checkOutput($sformatf("%s_rdata", tag), RDATA, expected);
    tick();
    checkOutput($sformatf("%s_ready_back", tag), {31'h0, READY}, 32'h1);
  endtask

  task automatic doReject(input string tag, input logic we, input logic [1:0] size, input logic [11:0] addr);
    int w0;
    w0 = wr_count;
    applyStimulus(we, size, 1'b0, addr, 32'hFFFF_FFFF);
    tick();
    REQ = 1'b0;
    checkOutput($sformatf("%s_err", tag), {31'h0, ERR}, 32'h1);
    checkOutput($sformatf("%s_ready", tag), {31'h0, READY}, 32'h1);
    checkOutput($sformatf("%s_ack", tag), {31'h0, ACK}, 32'h0);
    checkOutput($sformatf("%s_enw", tag), {31'h0, ENABLE_W}, 32'h0);
    tick();
    checkOutput($sformatf("%s_err_clr", tag), {31'h0, ERR}, 32'h0);
    checkOutput($sformatf("%s_ack2", tag), {31'h0, ACK}, 32'h0);
    checkOutput($sformatf("%s_writes", tag), 32'(wr_count - w0), 32'h0);
  endtask

  initial begin
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; SIZE = 2'b00; UNSIGNED = 1'b0;
    BYTE_ADDR = '0; WDATA = '0;
    tick();
    tick();
    RST = 1'b0;
    checkOutput("rst_ready", {31'h0, READY}, 32'h1);
    checkOutput("rst_ack", {31'h0, ACK}, 32'h0);
    checkOutput("rst_err", {31'h0, ERR}, 32'h0);
    checkOutput("rst_enw", {31'h0, ENABLE_W}, 32'h0);
    checkOutput("rst_rdata", RDATA, 32'h0);
    checkOutput("rst_addr_w", {22'h0, ADDR_W}, 32'h0);
    checkOutput("rst_addr_r", {22'h0, ADDR_R}, 32'h0);
    checkOutput("rst_q_w", Q_W, 32'h0);

    presetWord(10'd1, 32'h1122_3344);
    presetWord(10'd2, 32'h0000_F080);

    // Word store to 0x010 (RAM[4]).
    applyStimulus(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    checkOutput("sw_ready", {31'h0, READY}, 32'h1);
    tick();
    REQ = 1'b0;
    checkOutput("sw_busy", {31'h0, READY}, 32'h0);
    checkOutput("sw_enw", {31'h0, ENABLE_W}, 32'h1);
    checkOutput("sw_addr_w", {22'h0, ADDR_W}, 32'h4);
    checkOutput("sw_q_w", Q_W, 32'hDEAD_BEEF);
    tick();
    checkOutput("sw_ack", {31'h0, ACK}, 32'h1);
    checkOutput("sw_ram4", ram[4], 32'hDEAD_BEEF);
    tick();
    checkOutput("sw_ack_off", {31'h0, ACK}, 32'h0);
    checkOutput("sw_ready_back", {31'h0, READY}, 32'h1);

    doLoad("lw", 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);

    // Byte store 0xAB into lane 2 of RAM[1].
    wc = wr_count;
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h006, 32'h0000_00AB);
    tick();
    REQ = 1'b0;
    checkOutput("sb_addr_r", {22'h0, ADDR_R}, 32'h1);
    checkOutput("sb_rd_enw", {31'h0, ENABLE_W}, 32'h0);
    tick();
    checkOutput("sb_enw", {31'h0, ENABLE_W}, 32'h1);
    checkOutput("sb_addr_w", {22'h0, ADDR_W}, 32'h1);
    checkOutput("sb_q_w", Q_W, 32'h11AB_3344);
    checkOutput("sb_ack_early", {31'h0, ACK}, 32'h0);
    tick();
    checkOutput("sb_ack", {31'h0, ACK}, 32'h1);
    checkOutput("sb_ram1", ram[1], 32'h11AB_3344);
    tick();
    checkOutput("sb_writes", 32'(wr_count - wc), 32'h1);
    checkOutput("sb_ready_back", {31'h0, READY}, 32'h1);

    doLoad("lb_s", 2'b00, 1'b0, 12'h008, 32'hFFFF_FF80);
    doLoad("lb_u", 2'b00, 1'b1, 12'h008, 32'h0000_0080);
    doLoad("lh_s", 2'b01, 1'b0, 12'h008, 32'hFFFF_F080);

    doReject("rej_lw3", 1'b0, 2'b10, 12'h003);
    doReject("rej_sh5", 1'b1, 2'b01, 12'h005);
    doReject("rej_sz3", 1'b1, 2'b11, 12'h000);
    checkOutput("rej_ram1", ram[1], 32'h11AB_3344);

    // Three queued requests with REQ held: word load, word store, byte store.
    wc    = wr_count;
    ack_n = 0;
    acc_n = 0;
    for (int i = 0; i < 3; i++) ack_cyc[i] = 0;
    applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    for (int c = 0; c < 16; c++) begin
      if (ACK) begin
        if (ack_n < 3) ack_cyc[ack_n] = c;
        ack_n++;
        if (ack_n == 1) checkOutput("b2b_rdata", RDATA, 32'hDEAD_BEEF);
      end
      rdy = READY;
      tick();
      if (rdy && REQ) begin
        acc_n++;
        case (acc_n)
          1: applyStimulus(1'b1, 2'b10, 1'b0, 12'h00C, 32'h1234_5678);
          2: applyStimulus(1'b1, 2'b00, 1'b0, 12'h009, 32'h0000_005A);
          default: REQ = 1'b0;
        endcase
      end
    end
    checkOutput("b2b_acks", 32'(ack_n), 32'd3);
    checkOutput("b2b_accepts", 32'(acc_n), 32'd3);
    checkOutput("b2b_first_ack", 32'(ack_cyc[0]), 32'd2);
    checkOutput("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    checkOutput("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd4);
    checkOutput("b2b_writes", 32'(wr_count - wc), 32'd2);
    checkOutput("b2b_ram3", ram[3], 32'h1234_5678);
    checkOutput("b2b_ram2", ram[2], 32'h0000_5A80);

    // Reset asserted during the write cycle of a byte store.
    presetWord(10'd5, 32'hCAFE_BABE);
    wc = wr_count;
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h014, 32'h0000_00EE);
    tick();
    REQ = 1'b0;
    checkOutput("rm_addr_r", {22'h0, ADDR_R}, 32'h5);
    tick();
    checkOutput("rm_enw_pre", {31'h0, ENABLE_W}, 32'h1);
    RST = 1'b1;
    #1;
    checkOutput("rm_enw_rst", {31'h0, ENABLE_W}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checkOutput("rm_ready", {31'h0, READY}, 32'h1);
    checkOutput("rm_ack", {31'h0, ACK}, 32'h0);
    checkOutput("rm_err", {31'h0, ERR}, 32'h0);
    checkOutput("rm_enw", {31'h0, ENABLE_W}, 32'h0);
    checkOutput("rm_rdata", RDATA, 32'h0);
    checkOutput("rm_addr_w", {22'h0, ADDR_W}, 32'h0);
    checkOutput("rm_addr_r0", {22'h0, ADDR_R}, 32'h0);
    checkOutput("rm_q_w", Q_W, 32'h0);
    checkOutput("rm_ram5", ram[5], 32'hCAFE_BABE);
    checkOutput("rm_writes", 32'(wr_count - wc), 32'h0);
    tick();
    checkOutput("rm_ack_after", {31'h0, ACK}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end that drives the data-memory RAM from the core side: it accepts one byte, halfword or word access at a time, generates the RAM write port (ADDR_W, ENABLE_W, Q_W) and read address (ADDR_R), and returns sign- or zero-extended load data. Sub-word stores are done as read-modify-write, because the RAM has no byte enables. It sits between the RISC-V execute/memory stage and the data RAM. The RAM read is combinational and its write is synchronous.

## Interface
Parameters:
- data_width, 32, word size; only 32 is supported.
- addr_width, 10, RAM word-address width; the byte address is addr_width+2 bits.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ  in  1  access request; sampled only while READY=1.
- WE  in  1  1=store, 0=load.
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- UNSIGNED  in  1  load extension: 1=zero-extend, 0=sign-extend.
- BYTE_ADDR  in  addr_width+2  byte address.
- WDATA  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- READY  out  1  unit is idle and can accept a request.
- ACK  out  1  one-cycle pulse when an access completes.
- ERR  out  1  one-cycle pulse when a misaligned or illegal request is rejected.
- RDATA  out  32  extended load data; valid while ACK=1 for a load, held until the next load completes.
- ADDR_W  out  addr_width  RAM write word address.
- ENABLE_W  out  1  RAM write enable.
- Q_W  out  32  RAM write data.
- ADDR_R  out  addr_width  RAM read word address.
- Q_R  in  32  RAM read data, combinational from ADDR_R.

## Operation
- Word address: BYTE_ADDR[addr_width+1:2]. Byte lane: BYTE_ADDR[1:0]. Little-endian; lane k is bits [8k+7:8k].
- Accept condition: REQ=1 and READY=1 at a rising edge. On accept, WE, SIZE, UNSIGNED, BYTE_ADDR and WDATA are latched. REQ while READY=0 is ignored, and the requester holds REQ until it is accepted.
- Rejection: a request is rejected if SIZE=11, or SIZE=01 with BYTE_ADDR[0]=1, or SIZE=10 with BYTE_ADDR[1:0]≠00. The unit stays in IDLE, performs no RAM access and raises ERR for exactly the next cycle; READY stays 1.
- States:
  - IDLE: READY=1.
  - RD: ADDR_R = latched word address; Q_R is captured into a 32-bit buffer at the end of the cycle.
  - WR: ENABLE_W=1 with ADDR_W and Q_W driven.
  - DONE: ACK=1.
- Transitions:
  - Load: IDLE → RD → DONE → IDLE. In RD, the selected lane(s) are extracted, extended per UNSIGNED and registered into RDATA.
  - Word store: IDLE → WR → DONE → IDLE. Q_W = latched WDATA.
  - Byte or halfword store: IDLE → RD → WR → DONE → IDLE. Q_W = buffered old word with the target lane(s) replaced by WDATA[7:0] or WDATA[15:0]; other bytes are unchanged.
- ENABLE_W = (state==WR) and not RST. A write never commits in a cycle where RST=1.
- ADDR_W, Q_W and ADDR_R hold their last values outside RD/WR. Their value there is don't-care for the RAM, but it must be deterministic.

## Timing
- Request accepted at edge N (cycle N = the cycle REQ is presented):
  - Load: ACK and RDATA valid in cycle N+2.
  - Word store: write commits at the end of cycle N+1; ACK in cycle N+2.
  - Sub-word store: read in cycle N+1, write commits at the end of N+2, ACK in N+3.
- READY=0 from cycle N+1 through the DONE cycle, and returns to 1 the cycle after DONE. The next accept can occur at the end of that cycle. Minimum spacing is 3 cycles for loads and word stores, 4 for sub-word stores.
- Rejected request at edge N: ERR=1 in cycle N+1. A new request may be accepted at edge N+1.
- Reset values (RST=1 at an edge): state IDLE; READY=1, ACK=0, ERR=0, ENABLE_W=0, RDATA=0, ADDR_W=0, ADDR_R=0, Q_W=0, buffer=0.
- Reset during any non-IDLE state aborts the access: no ACK, and no partial write.

## Test plan
- Word store then load: store 0xDEADBEEF to byte address 0x010, then load a word from 0x010 → RAM[4]=0xDEADBEEF after cycle N+1; the load returns RDATA=0xDEADBEEF with ACK at N+2.
- Byte read-modify-write: RAM[1]=0x11223344; store byte 0xAB to byte address 0x006 → RAM[1]=0x11AB3344, ACK at N+3, exactly one ENABLE_W cycle.
- Extension: RAM[2]=0x0000F080; byte load at 0x008 with UNSIGNED=0 → 0xFFFFFF80, with UNSIGNED=1 → 0x00000080; halfword load at 0x008 with UNSIGNED=0 → 0xFFFFF080.
- Misalignment: word load at 0x003, halfword store at 0x005, and any request with SIZE=11 → each gives a single ERR pulse and no ACK, ENABLE_W stays 0, READY stays 1, RAM unchanged.
- Back-to-back: REQ held high with three queued accesses → each is accepted only when READY=1, the ACK spacing is 3/3/4 cycles as specified, and REQ while busy causes no extra access.
- Reset mid-store: assert RST in the WR cycle of a byte store → ENABLE_W=0 that cycle, the RAM word is unchanged, no ACK, and all outputs are at their reset values the next cycle.
